// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-side (m0)
// and a data-side (m1) requester. One transaction at a time, round-robin on
// ties, writes ahead of reads when one port presents both in the same cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // m0: instruction side
  input  logic                  m0_r_request_valid,
  output logic                  m0_r_request_ready,
  input  logic [ADDR_WIDTH-1:0] m0_r_raddr,
  output logic                  m0_r_reply_valid,
  input  logic                  m0_r_reply_ready,
  output logic [DATA_WIDTH-1:0] m0_r_rdata,
  input  logic                  m0_w_request_valid,
  output logic                  m0_w_request_ready,
  input  logic [ADDR_WIDTH-1:0] m0_w_waddr,
  input  logic [DATA_WIDTH-1:0] m0_w_wdata,
  input  logic [MASK_WIDTH-1:0] m0_w_wmask,
  output logic                  m0_w_reply_valid,
  input  logic                  m0_w_reply_ready,
  // m1: data side
  input  logic                  m1_r_request_valid,
  output logic                  m1_r_request_ready,
  input  logic [ADDR_WIDTH-1:0] m1_r_raddr,
  output logic                  m1_r_reply_valid,
  input  logic                  m1_r_reply_ready,
  output logic [DATA_WIDTH-1:0] m1_r_rdata,
  input  logic                  m1_w_request_valid,
  output logic                  m1_w_request_ready,
  input  logic [ADDR_WIDTH-1:0] m1_w_waddr,
  input  logic [DATA_WIDTH-1:0] m1_w_wdata,
  input  logic [MASK_WIDTH-1:0] m1_w_wmask,
  output logic                  m1_w_reply_valid,
  input  logic                  m1_w_reply_ready,
  // s: shared memory
  output logic                  s_r_request_valid,
  input  logic                  s_r_request_ready,
  output logic [ADDR_WIDTH-1:0] s_r_raddr,
  input  logic                  s_r_reply_valid,
  output logic                  s_r_reply_ready,
  input  logic [DATA_WIDTH-1:0] s_r_rdata,
  output logic                  s_w_request_valid,
  input  logic                  s_w_request_ready,
  output logic [ADDR_WIDTH-1:0] s_w_waddr,
  output logic [DATA_WIDTH-1:0] s_w_wdata,
  output logic [MASK_WIDTH-1:0] s_w_wmask,
  input  logic                  s_w_reply_valid,
  output logic                  s_w_reply_ready,
  // status
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // owner: 0 = m0, 1 = m1; op: 0 = read, 1 = write
  state_t state_r, state_nxt_s;
  logic   owner_r, owner_nxt_s;
  logic   op_r, op_nxt_s;
  logic   rr_last_r, rr_last_nxt_s;

  logic cand0_s, cand1_s, win_s, win_op_s;
  logic own_r_req_valid_s, own_w_req_valid_s;
  logic own_r_rep_ready_s, own_w_rep_ready_s;
  logic req_valid_s, req_ready_s, rep_valid_s, rep_ready_s;

  assign cand0_s = m0_r_request_valid | m0_w_request_valid;
  assign cand1_s = m1_r_request_valid | m1_w_request_valid;

  // Pick the winner: sole candidate wins, a tie goes to the port not served last.
  always_comb begin
    win_s    = 1'b0;
    win_op_s = 1'b0;
    if (cand0_s && cand1_s) begin
      win_s = ~rr_last_r;
    end else begin
      win_s = cand1_s;
    end
    if (win_s) begin
      win_op_s = m1_w_request_valid;
    end else begin
      win_op_s = m0_w_request_valid;
    end
  end

  // Select the current owner's handshake inputs.
  always_comb begin
    own_r_req_valid_s = 1'b0;
    own_w_req_valid_s = 1'b0;
    own_r_rep_ready_s = 1'b0;
    own_w_rep_ready_s = 1'b0;
    if (owner_r) begin
      own_r_req_valid_s = m1_r_request_valid;
      own_w_req_valid_s = m1_w_request_valid;
      own_r_rep_ready_s = m1_r_reply_ready;
      own_w_rep_ready_s = m1_w_reply_ready;
    end else begin
      own_r_req_valid_s = m0_r_request_valid;
      own_w_req_valid_s = m0_w_request_valid;
      own_r_rep_ready_s = m0_r_reply_ready;
      own_w_rep_ready_s = m0_w_reply_ready;
    end
  end

  // Handshake terms for the channel selected by op.
  always_comb begin
    req_valid_s = 1'b0;
    req_ready_s = 1'b0;
    rep_valid_s = 1'b0;
    rep_ready_s = 1'b0;
    if (op_r) begin
      req_valid_s = own_w_req_valid_s;
      req_ready_s = s_w_request_ready;
      rep_valid_s = s_w_reply_valid;
      rep_ready_s = own_w_rep_ready_s;
    end else begin
      req_valid_s = own_r_req_valid_s;
      req_ready_s = s_r_request_ready;
      rep_valid_s = s_r_reply_valid;
      rep_ready_s = own_r_rep_ready_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, forward request in REQ, await reply in RESP.
  always_comb begin
    state_nxt_s   = state_r;
    owner_nxt_s   = owner_r;
    op_nxt_s      = op_r;
    rr_last_nxt_s = rr_last_r;
    case (state_r)
      ST_IDLE: begin
        if (cand0_s || cand1_s) begin
          state_nxt_s   = ST_REQ;
          owner_nxt_s   = win_s;
          op_nxt_s      = win_op_s;
          rr_last_nxt_s = win_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A withdrawn request returns to IDLE without touching the memory.
        if (!req_valid_s) begin
          state_nxt_s = ST_IDLE;
        end else if (req_ready_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (rep_valid_s && rep_ready_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, op and round-robin history registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      op_r      <= 1'b0;
      rr_last_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      owner_r   <= owner_nxt_s;
      op_r      <= op_nxt_s;
      rr_last_r <= rr_last_nxt_s;
    end
  end

  // Status decoded purely from registered state.
  always_comb begin
    grant = 2'b00;
    busy  = 1'b0;
    if (state_r != ST_IDLE) begin
      busy  = 1'b1;
      grant = owner_r ? 2'b10 : 2'b01;
    end else begin
      busy  = 1'b0;
      grant = 2'b00;
    end
  end

  // Route the owner's selected channel to the memory; everything else held at zero.
  always_comb begin
    m0_r_request_ready = 1'b0;
    m0_w_request_ready = 1'b0;
    m0_r_reply_valid   = 1'b0;
    m0_w_reply_valid   = 1'b0;
    m0_r_rdata         = '0;
    m1_r_request_ready = 1'b0;
    m1_w_request_ready = 1'b0;
    m1_r_reply_valid   = 1'b0;
    m1_w_reply_valid   = 1'b0;
    m1_r_rdata         = '0;
    s_r_request_valid  = 1'b0;
    s_r_raddr          = '0;
    s_r_reply_ready    = 1'b0;
    s_w_request_valid  = 1'b0;
    s_w_waddr          = '0;
    s_w_wdata          = '0;
    s_w_wmask          = '0;
    s_w_reply_ready    = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (op_r) begin
          s_w_request_valid = own_w_req_valid_s;
          if (owner_r) begin
            s_w_waddr          = m1_w_waddr;
            s_w_wdata          = m1_w_wdata;
            s_w_wmask          = m1_w_wmask;
            m1_w_request_ready = s_w_request_ready;
          end else begin
            s_w_waddr          = m0_w_waddr;
            s_w_wdata          = m0_w_wdata;
            s_w_wmask          = m0_w_wmask;
            m0_w_request_ready = s_w_request_ready;
          end
        end else begin
          s_r_request_valid = own_r_req_valid_s;
          if (owner_r) begin
            s_r_raddr          = m1_r_raddr;
            m1_r_request_ready = s_r_request_ready;
          end else begin
            s_r_raddr          = m0_r_raddr;
            m0_r_request_ready = s_r_request_ready;
          end
        end
      end
      ST_RESP: begin
        if (op_r) begin
          s_w_reply_ready = own_w_rep_ready_s;
          if (owner_r) begin
            m1_w_reply_valid = s_w_reply_valid;
          end else begin
            m0_w_reply_valid = s_w_reply_valid;
          end
        end else begin
          s_r_reply_ready = own_r_rep_ready_s;
          if (owner_r) begin
            m1_r_reply_valid = s_r_reply_valid;
            m1_r_rdata       = s_r_rdata;
          end else begin
            m0_r_reply_valid = s_r_reply_valid;
            m0_r_rdata       = s_r_rdata;
          end
        end
      end
      default: begin
        s_r_request_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, reset tie-break,
// round-robin, backpressure, reset mid-reply and write-before-read.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_r_request_valid, m0_r_request_ready, m0_r_reply_valid, m0_r_reply_ready;
  logic [63:0] m0_r_raddr, m0_r_rdata;
  logic        m0_w_request_valid, m0_w_request_ready, m0_w_reply_valid, m0_w_reply_ready;
  logic [63:0] m0_w_waddr, m0_w_wdata;
  logic [7:0]  m0_w_wmask;
  logic        m1_r_request_valid, m1_r_request_ready, m1_r_reply_valid, m1_r_reply_ready;
  logic [63:0] m1_r_raddr, m1_r_rdata;
  logic        m1_w_request_valid, m1_w_request_ready, m1_w_reply_valid, m1_w_reply_ready;
  logic [63:0] m1_w_waddr, m1_w_wdata;
  logic [7:0]  m1_w_wmask;
  logic        s_r_request_valid, s_r_request_ready, s_r_reply_valid, s_r_reply_ready;
  logic [63:0] s_r_raddr, s_r_rdata;
  logic        s_w_request_valid, s_w_request_ready, s_w_reply_valid, s_w_reply_ready;
  logic [63:0] s_w_waddr, s_w_wdata;
  logic [7:0]  s_w_wmask;
  logic [1:0]  grant;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .m0_r_request_valid(m0_r_request_valid), .m0_r_request_ready(m0_r_request_ready),
    .m0_r_raddr(m0_r_raddr), .m0_r_reply_valid(m0_r_reply_valid),
    .m0_r_reply_ready(m0_r_reply_ready), .m0_r_rdata(m0_r_rdata),
    .m0_w_request_valid(m0_w_request_valid), .m0_w_request_ready(m0_w_request_ready),
    .m0_w_waddr(m0_w_waddr), .m0_w_wdata(m0_w_wdata), .m0_w_wmask(m0_w_wmask),
    .m0_w_reply_valid(m0_w_reply_valid), .m0_w_reply_ready(m0_w_reply_ready),
    .m1_r_request_valid(m1_r_request_valid), .m1_r_request_ready(m1_r_request_ready),
    .m1_r_raddr(m1_r_raddr), .m1_r_reply_valid(m1_r_reply_valid),
    .m1_r_reply_ready(m1_r_reply_ready), .m1_r_rdata(m1_r_rdata),
    .m1_w_request_valid(m1_w_request_valid), .m1_w_request_ready(m1_w_request_ready),
    .m1_w_waddr(m1_w_waddr), .m1_w_wdata(m1_w_wdata), .m1_w_wmask(m1_w_wmask),
    .m1_w_reply_valid(m1_w_reply_valid), .m1_w_reply_ready(m1_w_reply_ready),
    .s_r_request_valid(s_r_request_valid), .s_r_request_ready(s_r_request_ready),
    .s_r_raddr(s_r_raddr), .s_r_reply_valid(s_r_reply_valid),
    .s_r_reply_ready(s_r_reply_ready), .s_r_rdata(s_r_rdata),
    .s_w_request_valid(s_w_request_valid), .s_w_request_ready(s_w_request_ready),
    .s_w_waddr(s_w_waddr), .s_w_wdata(s_w_wdata), .s_w_wmask(s_w_wmask),
    .s_w_reply_valid(s_w_reply_valid), .s_w_reply_ready(s_w_reply_ready),
    .grant(grant), .busy(busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_r_request_valid = 1'b0; m0_r_raddr = 64'h0; m0_r_reply_ready = 1'b0;
    m0_w_request_valid = 1'b0; m0_w_waddr = 64'h0; m0_w_wdata = 64'h0;
    m0_w_wmask = 8'h0; m0_w_reply_ready = 1'b0;
    m1_r_request_valid = 1'b0; m1_r_raddr = 64'h0; m1_r_reply_ready = 1'b0;
    m1_w_request_valid = 1'b0; m1_w_waddr = 64'h0; m1_w_wdata = 64'h0;
    m1_w_wmask = 8'h0; m1_w_reply_ready = 1'b0;
    s_r_request_ready = 1'b0; s_r_reply_valid = 1'b0; s_r_rdata = 64'h0;
    s_w_request_ready = 1'b0; s_w_reply_valid = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus and checks.
  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_s_rvalid", 64'(s_r_request_valid), 64'h0);
    chk("rst_s_wvalid", 64'(s_w_request_valid), 64'h0);
    rst = 1'b0;

    // Single read on m0
    m0_r_request_valid = 1'b1; m0_r_raddr = 64'h1000; s_r_request_ready = 1'b1;
    #2;
    chk("rd_idle_busy", 64'(busy), 64'h0);
    chk("rd_idle_m0_rdy", 64'(m0_r_request_ready), 64'h0);
    chk("rd_idle_s_rvalid", 64'(s_r_request_valid), 64'h0);
    tick();
    chk("rd_req_s_rvalid", 64'(s_r_request_valid), 64'h1);
    chk("rd_req_s_raddr", s_r_raddr, 64'h1000);
    chk("rd_req_grant", 64'(grant), 64'h1);
    chk("rd_req_busy", 64'(busy), 64'h1);
    chk("rd_req_m0_rdy", 64'(m0_r_request_ready), 64'h1);
    tick();
    m0_r_request_valid = 1'b0; s_r_reply_valid = 1'b1;
    s_r_rdata = 64'hDEADBEEF_00000013; m0_r_reply_ready = 1'b1;
    #2;
    chk("rd_resp_m0_vld", 64'(m0_r_reply_valid), 64'h1);
    chk("rd_resp_rdata", m0_r_rdata, 64'hDEADBEEF_00000013);
    chk("rd_resp_busy", 64'(busy), 64'h1);
    chk("rd_resp_s_rdy", 64'(s_r_reply_ready), 64'h1);
    chk("rd_resp_s_rvalid", 64'(s_r_request_valid), 64'h0);
    chk("rd_resp_s_raddr", s_r_raddr, 64'h0);
    tick();
    clear_inputs();
    #2;
    chk("rd_done_busy", 64'(busy), 64'h0);
    chk("rd_done_grant", 64'(grant), 64'h0);

    // Simultaneous requests right after reset: m1 wins the first tie
    rst = 1'b1; #2; rst = 1'b0;
    m0_r_request_valid = 1'b1; m0_r_raddr = 64'h0;
    m1_w_request_valid = 1'b1; m1_w_waddr = 64'h2000; m1_w_wdata = 64'h55; m1_w_wmask = 8'h0F;
    s_w_request_ready = 1'b1; s_r_request_ready = 1'b1;
    #2;
    chk("tie_idle_m0_rdy", 64'(m0_r_request_ready), 64'h0);
    tick();
    chk("tie_req_grant", 64'(grant), 64'h2);
    chk("tie_s_wvalid", 64'(s_w_request_valid), 64'h1);
    chk("tie_s_waddr", s_w_waddr, 64'h2000);
    chk("tie_s_wmask", 64'(s_w_wmask), 64'h0F);
    chk("tie_s_wdata", s_w_wdata, 64'h55);
    chk("tie_m1_wrdy", 64'(m1_w_request_ready), 64'h1);
    chk("tie_m0_rdy_req", 64'(m0_r_request_ready), 64'h0);
    tick();
    m1_w_request_valid = 1'b0; s_w_reply_valid = 1'b1; m1_w_reply_ready = 1'b1;
    #2;
    chk("tie_m1_wrep", 64'(m1_w_reply_valid), 64'h1);
    chk("tie_m0_rdy_resp", 64'(m0_r_request_ready), 64'h0);
    tick();
    s_w_reply_valid = 1'b0; m1_w_reply_ready = 1'b0;
    #2;
    chk("tie_idle2_grant", 64'(grant), 64'h0);
    chk("tie_idle2_m0_rdy", 64'(m0_r_request_ready), 64'h0);
    tick();
    chk("tie_m0_grant", 64'(grant), 64'h1);
    chk("tie_m0_rdy", 64'(m0_r_request_ready), 64'h1);
    chk("tie_m0_s_raddr", s_r_raddr, 64'h0);
    tick();
    m0_r_request_valid = 1'b0; s_r_reply_valid = 1'b1; s_r_rdata = 64'h1234; m0_r_reply_ready = 1'b1;
    #2;
    chk("tie_m0_rdata", m0_r_rdata, 64'h1234);
    tick();
    clear_inputs();

    // Round-robin with both ports requesting continuously
    m0_r_request_valid = 1'b1; m1_r_request_valid = 1'b1;
    s_r_request_ready = 1'b1; s_r_reply_valid = 1'b1; s_r_rdata = 64'hA5;
    m0_r_reply_ready = 1'b1; m1_r_reply_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_req_grant", 64'(grant), (i % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      chk("rr_resp_grant", 64'(grant), (i % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      chk("rr_idle_grant", 64'(grant), 64'h0);
    end
    clear_inputs();

    // Slave backpressure on m1 write while m0 read waits
    m1_w_request_valid = 1'b1; m1_w_waddr = 64'h3000; m1_w_wdata = 64'hAA; m1_w_wmask = 8'hFF;
    m0_r_request_valid = 1'b1; m0_r_raddr = 64'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_grant", 64'(grant), 64'h2);
      chk("bp_busy", 64'(busy), 64'h1);
      chk("bp_m1_wrdy", 64'(m1_w_request_ready), 64'h0);
      chk("bp_m0_rdy", 64'(m0_r_request_ready), 64'h0);
      chk("bp_s_wvalid", 64'(s_w_request_valid), 64'h1);
    end
    s_w_request_ready = 1'b1;
    #2;
    chk("bp_release_rdy", 64'(m1_w_request_ready), 64'h1);
    tick();
    m1_w_request_valid = 1'b0; s_w_reply_valid = 1'b1; m1_w_reply_ready = 1'b1;
    #2;
    chk("bp_wrep", 64'(m1_w_reply_valid), 64'h1);
    tick();
    s_w_reply_valid = 1'b0; s_r_request_ready = 1'b1;
    #2;
    chk("bp_idle_grant", 64'(grant), 64'h0);
    tick();
    chk("bp_m0_grant", 64'(grant), 64'h1);
    chk("bp_m0_raddr", s_r_raddr, 64'h40);
    tick();
    m0_r_request_valid = 1'b0; s_r_reply_valid = 1'b1; s_r_rdata = 64'h77; m0_r_reply_ready = 1'b1;
    #2;
    chk("bp_m0_rdata", m0_r_rdata, 64'h77);
    tick();
    clear_inputs();

    // Reset while the reply is pending
    m0_r_request_valid = 1'b1; m0_r_raddr = 64'h80; s_r_request_ready = 1'b1;
    tick();
    chk("rstm_req_grant", 64'(grant), 64'h1);
    tick();
    m0_r_request_valid = 1'b0; m0_r_reply_ready = 1'b1;
    #2;
    chk("rstm_resp_busy", 64'(busy), 64'h1);
    rst = 1'b1; s_r_reply_valid = 1'b1; s_r_rdata = 64'h99;
    #1;
    chk("rstm_grant", 64'(grant), 64'h0);
    chk("rstm_busy", 64'(busy), 64'h0);
    chk("rstm_m0_rep", 64'(m0_r_reply_valid), 64'h0);
    chk("rstm_m0_rdata", m0_r_rdata, 64'h0);
    chk("rstm_s_rdy", 64'(s_r_reply_ready), 64'h0);
    tick();
    rst = 1'b0; s_r_reply_valid = 1'b0;
    m0_r_request_valid = 1'b1; m0_r_raddr = 64'hC0;
    #2;
    chk("rstm_idle_grant", 64'(grant), 64'h0);
    tick();
    chk("rstm_next_grant", 64'(grant), 64'h1);
    chk("rstm_next_raddr", s_r_raddr, 64'hC0);
    tick();
    m0_r_request_valid = 1'b0; s_r_reply_valid = 1'b1; s_r_rdata = 64'hBEEF;
    #2;
    chk("rstm_next_rdata", m0_r_rdata, 64'hBEEF);
    chk("rstm_next_rep", 64'(m0_r_reply_valid), 64'h1);
    tick();
    clear_inputs();
    #2;
    chk("rstm_done_busy", 64'(busy), 64'h0);

    // m1 presents read and write together: write goes first
    m1_r_request_valid = 1'b1; m1_r_raddr = 64'h500;
    m1_w_request_valid = 1'b1; m1_w_waddr = 64'h600; m1_w_wdata = 64'h1; m1_w_wmask = 8'h01;
    s_w_request_ready = 1'b1; s_r_request_ready = 1'b1;
    tick();
    chk("rw_s_wvalid", 64'(s_w_request_valid), 64'h1);
    chk("rw_s_waddr", s_w_waddr, 64'h600);
    chk("rw_s_rvalid", 64'(s_r_request_valid), 64'h0);
    chk("rw_m1_rrdy", 64'(m1_r_request_ready), 64'h0);
    tick();
    m1_w_request_valid = 1'b0; s_w_reply_valid = 1'b1; m1_w_reply_ready = 1'b1;
    #2;
    chk("rw_wrep", 64'(m1_w_reply_valid), 64'h1);
    tick();
    s_w_reply_valid = 1'b0;
    #2;
    chk("rw_idle_grant", 64'(grant), 64'h0);
    tick();
    chk("rw_rd_grant", 64'(grant), 64'h2);
    chk("rw_s_rvalid2", 64'(s_r_request_valid), 64'h1);
    chk("rw_s_raddr", s_r_raddr, 64'h500);
    chk("rw_m1_rrdy2", 64'(m1_r_request_ready), 64'h1);
    tick();
    m1_r_request_valid = 1'b0; s_r_reply_valid = 1'b1; m1_r_reply_ready = 1'b1; s_r_rdata = 64'hABC;
    #2;
    chk("rw_m1_rdata", m1_r_rdata, 64'hABC);
    chk("rw_m0_rdata", m0_r_rdata, 64'h0);
    tick();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
